// File: rtl/raw_bayer_gray_conv.sv
// raw_bayer_gray_conv: Bayer RAW to greyscale via a 2x2 window over a circular line buffer
module raw_bayer_gray_conv #(
  parameter int DW      = 12,
  parameter int XW      = 11,
  parameter int LINE_W  = 1280,
  parameter int PATTERN = 0,
  parameter int LUMA    = 0
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic [DW-1:0] iDATA,
  input  logic          iDVAL,
  input  logic [XW-1:0] iX_Cont,
  input  logic [XW-1:0] iY_Cont,
  input  logic          iFULL,
  output logic [DW-1:0] oGrey,
  output logic [XW-1:0] oX,
  output logic [XW-1:0] oY,
  output logic          oDVAL
);
  localparam int AW = $clog2(LINE_W);
  logic [DW-1:0] mem_q [LINE_W];
  logic          acc, emit_d, emit_q, dval_q;
  logic [DW-1:0] above, left_q, abl_q;
  logic [DW-1:0] p00_q, p01_q, p10_q, p11_q;
  logic [1:0]    ph_d, ph_q;
  logic [XW-1:0] x_q, y_q, ox_q, oy_q;
  logic [DW-1:0] r, b, g1, g2, grey_d, grey_q;
  logic [DW:0]   gs;
  logic [DW+1:0] s0;
  logic [DW+7:0] s1;
  assign acc    = iDVAL && ({1'b0, iX_Cont} < (XW+1)'(LINE_W));
  assign above  = mem_q[iX_Cont[AW-1:0]];
  assign emit_d = acc && iX_Cont != '0 && iY_Cont != '0 && (iFULL || (iX_Cont[0] && iY_Cont[0]));
  assign ph_d   = {iY_Cont[0], iX_Cont[0]} ^ 2'(PATTERN);
  // Line buffer: the old word (pixel above) is read combinationally before this write lands
  always_ff @(posedge iCLK)
    if (acc) mem_q[iX_Cont[AW-1:0]] <= iDATA;
  // Stage 1: shift the 2x2 window and latch phase/coords; only accepted pixels move the window
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) begin
      emit_q <= 1'b0;
      left_q <= '0;
      abl_q  <= '0;
      p00_q  <= '0;
      p01_q  <= '0;
      p10_q  <= '0;
      p11_q  <= '0;
      ph_q   <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      emit_q <= emit_d;
      if (acc) begin
        left_q <= iDATA;
        abl_q  <= above;
        p00_q  <= abl_q;
        p01_q  <= above;
        p10_q  <= left_q;
        p11_q  <= iDATA;
        ph_q   <= ph_d;
        x_q    <= x_q == x_q ? iX_Cont : x_q;
        y_q    <= iY_Cont;
      end
    end
  // Colour pick from the bottom-right phase: phase 0 -> P11 is R, 3 -> P11 is B, else G diagonal
  always_comb begin
    r      = ph_q == 2'd0 ? p11_q : ph_q == 2'd3 ? p00_q : ph_q == 2'd1 ? p10_q : p01_q;
    b      = ph_q == 2'd0 ? p00_q : ph_q == 2'd3 ? p11_q : ph_q == 2'd1 ? p01_q : p10_q;
    g1     = ^ph_q ? p11_q : p10_q;
    g2     = ^ph_q ? p00_q : p01_q;
    gs     = {1'b0, g1} + {1'b0, g2};
    s0     = (DW+2)'(r) + (DW+2)'(gs) + (DW+2)'(b);
    s1     = (DW+8)'(77) * (DW+8)'(r) + (DW+8)'(75) * (DW+8)'(gs) + (DW+8)'(29) * (DW+8)'(b);
    grey_d = LUMA != 0 ? DW'(s1 >> 8) : DW'(s0 >> 2);
  end
  // Stage 2: register the result; outputs hold between pulses
  always_ff @(posedge iCLK or posedge iRST)
    if (iRST) begin
      dval_q <= 1'b0;
      grey_q <= '0;
      ox_q   <= '0;
      oy_q   <= '0;
    end else begin
      dval_q <= emit_q;
      if (emit_q) begin
        grey_q <= grey_d;
        ox_q   <= x_q;
        oy_q   <= y_q;
      end
    end
  assign oGrey = grey_q;
  assign oX    = ox_q;
  assign oY    = oy_q;
  assign oDVAL = dval_q;
endmodule

// File: tb/tb_raw_bayer_gray_conv.sv
// tb_raw_bayer_gray_conv: scoreboard bench over four phase/luma variants fed the same stream
module tb_raw_bayer_gray_conv;
  logic        clk = 1'b0;
  logic        rst, dval, full;
  logic [11:0] data;
  logic [10:0] xc, yc;
  logic [11:0] grey [4];
  logic [10:0] ox [4], oy [4];
  logic        odv [4];
  int          tests = 0, fails = 0, cyc = 0;
  typedef struct {
    logic [3:0][11:0] g;
    logic [10:0]      x, y;
    int               c;
  } exp_t;
  exp_t sb [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  raw_bayer_gray_conv #(.DW(12), .XW(11), .LINE_W(8), .PATTERN(0), .LUMA(0)) u0 (
    .iCLK(clk), .iRST(rst), .iDATA(data), .iDVAL(dval), .iX_Cont(xc), .iY_Cont(yc), .iFULL(full),
    .oGrey(grey[0]), .oX(ox[0]), .oY(oy[0]), .oDVAL(odv[0]));
  raw_bayer_gray_conv #(.DW(12), .XW(11), .LINE_W(8), .PATTERN(0), .LUMA(1)) u1 (
    .iCLK(clk), .iRST(rst), .iDATA(data), .iDVAL(dval), .iX_Cont(xc), .iY_Cont(yc), .iFULL(full),
    .oGrey(grey[1]), .oX(ox[1]), .oY(oy[1]), .oDVAL(odv[1]));
  raw_bayer_gray_conv #(.DW(12), .XW(11), .LINE_W(8), .PATTERN(3), .LUMA(0)) u2 (
    .iCLK(clk), .iRST(rst), .iDATA(data), .iDVAL(dval), .iX_Cont(xc), .iY_Cont(yc), .iFULL(full),
    .oGrey(grey[2]), .oX(ox[2]), .oY(oy[2]), .oDVAL(odv[2]));
  raw_bayer_gray_conv #(.DW(12), .XW(11), .LINE_W(8), .PATTERN(3), .LUMA(1)) u3 (
    .iCLK(clk), .iRST(rst), .iDATA(data), .iDVAL(dval), .iX_Cont(xc), .iY_Cont(yc), .iFULL(full),
    .oGrey(grey[3]), .oX(ox[3]), .oY(oy[3]), .oDVAL(odv[3]));

  function automatic logic [3:0][11:0] mk(input int a, input int b, input int c, input int d);
    logic [3:0][11:0] v;
    v[0] = 12'(a);
    v[1] = 12'(b);
    v[2] = 12'(c);
    v[3] = 12'(d);
    return v;
  endfunction

  // Monitor: any pulse pops one expectation covering all four instances
  always @(negedge clk) begin
    if (odv[0] | odv[1] | odv[2] | odv[3]) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected pulse: got x=%0d y=%0d, required no output", ox[0], oy[0]);
      end else begin
        exp_t e;
        e = sb.pop_front();
        for (int k = 0; k < 4; k++) begin
          tests++;
          if (!odv[k] || grey[k] !== e.g[k] || ox[k] !== e.x || oy[k] !== e.y || cyc - e.c != 2) begin
            fails++;
            $display("FAIL result u%0d: got dv=%0b grey=%0d (%0d,%0d) lat=%0d, required grey=%0d (%0d,%0d) lat=2",
                     k, odv[k], grey[k], ox[k], oy[k], cyc - e.c, e.g[k], e.x, e.y);
          end
        end
      end
    end
  end

  task automatic idle();
    @(posedge clk);
    #1 dval = 1'b0;
  endtask

  task automatic frame(input int r, input int g, input int b, input bit f,
                       input logic [3:0][11:0] ex, input bit gaps, input bit extra, input int rst_row);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < (extra ? 11 : 8); x++) begin
        @(posedge clk);
        #1;
        if (y == rst_row && x == 3) begin
          rst  = 1'b1;
          dval = 1'b0;
          #1;
          for (int k = 0; k < 4; k++) begin
            tests++;
            if (odv[k] !== 1'b0 || grey[k] !== 12'd0) begin
              fails++;
              $display("FAIL mid-frame reset u%0d: got dv=%0b grey=%0d, required 0/0", k, odv[k], grey[k]);
            end
          end
          sb.delete();
          repeat (2) @(posedge clk);
          #1 rst = 1'b0;
          return;
        end
        dval = 1'b1;
        full = f;
        xc   = 11'(x);
        yc   = 11'(y);
        data = (x % 2 == 0 && y % 2 == 0) ? 12'(r) : (x % 2 == 1 && y % 2 == 1) ? 12'(b) : 12'(g);
        if (x < 8 && x >= 1 && y >= 1 && (f || (x % 2 == 1 && y % 2 == 1)))
          sb.push_back('{g: ex, x: 11'(x), y: 11'(y), c: cyc});
        if (gaps) idle();
      end
    idle();
    repeat (3) @(posedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL missing results: got %0d outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    rst  = 1'b1;
    dval = 1'b0;
    full = 1'b0;
    data = '0;
    xc   = '0;
    yc   = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (odv[k] !== 1'b0 || grey[k] !== 12'd0 || ox[k] !== 11'd0 || oy[k] !== 11'd0) begin
        fails++;
        $display("FAIL reset u%0d: got dv=%0b grey=%0d (%0d,%0d), required all 0", k, odv[k], grey[k], ox[k], oy[k]);
      end
    end
    rst = 1'b0;
    frame(400, 800, 1200, 1'b0, mk(800, 725, 800, 875), 1'b0, 1'b0, -1);
    frame(400, 800, 1200, 1'b1, mk(800, 725, 800, 875), 1'b0, 1'b0, -1);
    frame(1200, 800, 400, 1'b1, mk(800, 875, 800, 725), 1'b0, 1'b0, -1);
    frame(4095, 4095, 4095, 1'b1, mk(4095, 4095, 4095, 4095), 1'b0, 1'b0, -1);
    frame(0, 0, 0, 1'b1, mk(0, 0, 0, 0), 1'b0, 1'b0, -1);
    frame(400, 800, 1200, 1'b0, mk(800, 725, 800, 875), 1'b1, 1'b1, -1);
    frame(400, 800, 1200, 1'b1, mk(800, 725, 800, 875), 1'b0, 1'b0, 2);
    frame(400, 800, 1200, 1'b1, mk(800, 725, 800, 875), 1'b0, 1'b0, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
